// File: rtl/key_line_buffer_pkg.sv
// Shared keyboard-path definitions: ASCII constants, line-buffer FSM encoding
// and the default line depth.
package kbd_pkg;

  localparam int unsigned DEFAULT_DEPTH = 32;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam logic [0:0] ST_EDIT  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/key_line_buffer_if.sv
// Key-strobe input side and committed-line output stream of the line buffer.
interface key_line_buffer_if #(
  parameter int unsigned DEPTH = kbd_pkg::DEFAULT_DEPTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          key_stb;
  logic [7:0]    key_char;
  logic          key_del;
  logic          key_ret;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_char;
  logic          out_last;
  logic          busy;
  logic [AW:0]   line_count;
  logic [7:0]    last_char;
  logic          overflow;

  modport slave (
    input  key_stb, key_char, key_del, key_ret, out_ready,
    output out_valid, out_char, out_last, busy, line_count, last_char, overflow
  );

  modport master (
    output key_stb, key_char, key_del, key_ret, out_ready,
    input  out_valid, out_char, out_last, busy, line_count, last_char, overflow
  );

endinterface

// File: rtl/key_line_buffer_ram.sv
// DEPTH x 8 character store: one synchronous write port, one asynchronous read port.
module line_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/key_line_buffer.sv
// Line-editing buffer between the PS/2 decoder and the expression parser:
// collects characters, applies backspace, streams the line out on Enter.
module key_line_buffer
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  key_line_buffer_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] TWO   = (AW+1)'(2);

  logic [0:0]    state_q,     state_d;
  logic [AW:0]   count_q,     count_d;
  logic [AW:0]   len_q,       len_d;
  logic [AW-1:0] rd_idx_q,    rd_idx_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q,  out_char_d;
  logic          out_last_q,  out_last_d;
  logic [7:0]    last_char_q, last_char_d;
  logic          overflow_q,  overflow_d;

  logic          we;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] next_idx;

  line_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (CLOCK_50),
    .we_i    (we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (bus.key_char),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign next_idx = rd_idx_q + 1'b1;

  // Single read port: output registers are loaded with the character for the
  // coming cycle, so the address looks one step ahead of the state.
  always_comb begin
    if (state_q == ST_DRAIN)  rd_addr = next_idx;
    else if (bus.key_ret)     rd_addr = '0;
    else                      rd_addr = AW'(count_q - TWO);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_last_d  = out_last_q;
    last_char_d = last_char_q;
    overflow_d  = 1'b0;
    we          = 1'b0;
    case (state_q)
      ST_EDIT: begin
        if (bus.key_ret) begin
          if (count_q != '0) begin
            state_d     = ST_DRAIN;
            len_d       = count_q;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_char_d  = rd_data;
            out_last_d  = (count_q == ONE);
          end
        end else if (bus.key_del) begin
          if (count_q != '0) begin
            count_d     = count_q - ONE;
            last_char_d = (count_q == ONE) ? '0 : rd_data;
          end
        end else if (bus.key_stb) begin
          if (count_q != FULL) begin
            we          = 1'b1;
            count_d     = count_q + ONE;
            last_char_d = bus.key_char;
          end else begin
            overflow_d  = 1'b1;
          end
        end
      end
      default: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = ST_EDIT;
            count_d     = '0;
            last_char_d = '0;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
            out_char_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            rd_idx_d    = next_idx;
            out_char_d  = rd_data;
            out_last_d  = ({1'b0, next_idx} == (len_q - ONE));
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_EDIT;
      count_q     <= '0;
      len_q       <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_last_q  <= 1'b0;
      last_char_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      last_char_q <= last_char_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_char   = out_char_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (state_q == ST_DRAIN);
  assign bus.line_count = count_q;
  assign bus.last_char  = last_char_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_key_line_buffer.sv
// Bench for key_line_buffer: edit-vector table plus a stream scoreboard.
module tb_key_line_buffer;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  key_line_buffer_if #(.DEPTH(DEPTH)) bus ();

  key_line_buffer #(.DEPTH(DEPTH)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  typedef enum int { OP_STB, OP_DEL, OP_RET, OP_RETSTB, OP_DELSTB, OP_WAIT } op_e;

  typedef struct {
    op_e        op;
    logic [7:0] ch;
    int         cnt;
    logic [7:0] lc;
    bit         bsy;
  } vec_t;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   beats = 0;
  bit   rdy_rand = 1'b0;
  exp_t exp_q[$];
  logic [7:0] mline[$];
  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready changes just after posedge so it is stable when sampled at negedge
  initial bus.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (resetn && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_beat: got char %0h expected no beat", bus.out_char);
      end else begin
        chk("out_char", int'(bus.out_char), int'(exp_q[0].ch));
        chk("out_last", int'(bus.out_last), int'(exp_q[0].last));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  task automatic commit_model();
    for (int i = 0; i < mline.size(); i++)
      exp_q.push_back('{mline[i], (i == mline.size() - 1)});
    mline.delete();
  endtask

  task automatic apply(input op_e op, input logic [7:0] ch);
    @(negedge clk);
    bus.key_char = ch;
    bus.key_stb  = (op == OP_STB) || (op == OP_RETSTB) || (op == OP_DELSTB);
    bus.key_del  = (op == OP_DEL) || (op == OP_DELSTB);
    bus.key_ret  = (op == OP_RET) || (op == OP_RETSTB);
    if (bus.key_ret) begin
      if (mline.size() > 0) commit_model();
    end else if (bus.key_del) begin
      if (mline.size() > 0) void'(mline.pop_back());
    end else if (mline.size() < DEPTH) begin
      mline.push_back(ch);
    end
    @(negedge clk);
    bus.key_stb = 1'b0;
    bus.key_del = 1'b0;
    bus.key_ret = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) break;
    end
    chk("drain_done", int'(i < 2000), 1);
  endtask

  task automatic check_state(input string tag, input int cnt, input logic [7:0] lc, input bit bsy);
    chk({tag, ".line_count"}, int'(bus.line_count), cnt);
    chk({tag, ".last_char"},  int'(bus.last_char),  int'(lc));
    chk({tag, ".busy"},       int'(bus.busy),       int'(bsy));
    chk({tag, ".out_valid"},  int'(bus.out_valid),  int'(bsy));
    chk({tag, ".overflow"},   int'(bus.overflow),   0);
  endtask

  initial begin
    int b0;
    bus.key_stb  = 1'b0;
    bus.key_del  = 1'b0;
    bus.key_ret  = 1'b0;
    bus.key_char = '0;

    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_state("reset", 0, 8'h00, 1'b0);
    chk("reset.out_last", int'(bus.out_last), 0);
    chk("reset.out_char", int'(bus.out_char), 0);

    // "12+3", backspace edit "45<BS>6", empty-line strobes, coincident strobes
    tv.push_back('{OP_STB,    8'h31, 1, 8'h31, 1'b0});
    tv.push_back('{OP_STB,    8'h32, 2, 8'h32, 1'b0});
    tv.push_back('{OP_STB,    8'h2B, 3, 8'h2B, 1'b0});
    tv.push_back('{OP_STB,    8'h33, 4, 8'h33, 1'b0});
    tv.push_back('{OP_RET,    8'h00, 4, 8'h33, 1'b1});
    tv.push_back('{OP_WAIT,   8'h00, 0, 8'h00, 1'b0});
    tv.push_back('{OP_STB,    8'h34, 1, 8'h34, 1'b0});
    tv.push_back('{OP_STB,    8'h35, 2, 8'h35, 1'b0});
    tv.push_back('{OP_DEL,    8'h00, 1, 8'h34, 1'b0});
    tv.push_back('{OP_STB,    8'h36, 2, 8'h36, 1'b0});
    tv.push_back('{OP_RET,    8'h00, 2, 8'h36, 1'b1});
    tv.push_back('{OP_WAIT,   8'h00, 0, 8'h00, 1'b0});
    tv.push_back('{OP_DEL,    8'h00, 0, 8'h00, 1'b0});
    tv.push_back('{OP_RET,    8'h00, 0, 8'h00, 1'b0});
    tv.push_back('{OP_STB,    8'h41, 1, 8'h41, 1'b0});
    tv.push_back('{OP_STB,    8'h42, 2, 8'h42, 1'b0});
    tv.push_back('{OP_RETSTB, 8'h58, 2, 8'h42, 1'b1});
    tv.push_back('{OP_WAIT,   8'h00, 0, 8'h00, 1'b0});
    tv.push_back('{OP_STB,    8'h43, 1, 8'h43, 1'b0});
    tv.push_back('{OP_STB,    8'h44, 2, 8'h44, 1'b0});
    tv.push_back('{OP_DELSTB, 8'h59, 1, 8'h43, 1'b0});
    tv.push_back('{OP_DEL,    8'h00, 0, 8'h00, 1'b0});

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].op == OP_WAIT) wait_drain();
      else apply(tv[i].op, tv[i].ch);
      check_state($sformatf("vec%0d", i), tv[i].cnt, tv[i].lc, tv[i].bsy);
    end

    // Fill to DEPTH, overflow pulse, then drain under random backpressure
    for (int i = 0; i < DEPTH; i++) apply(OP_STB, 8'h41 + 8'(i));
    chk("fill.line_count", int'(bus.line_count), DEPTH);
    chk("fill.last_char",  int'(bus.last_char),  'h60);
    apply(OP_STB, 8'h5A);
    chk("ovf.pulse",      int'(bus.overflow),   1);
    chk("ovf.line_count", int'(bus.line_count), DEPTH);
    @(negedge clk);
    chk("ovf.clear",      int'(bus.overflow),   0);

    rdy_rand = 1'b1;
    b0 = beats;
    apply(OP_RET, 8'h00);
    chk("drain.latency", int'(bus.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.key_char = 8'h7A;
      bus.key_stb  = 1'b1;
      @(negedge clk);
      bus.key_stb  = 1'b0;
      chk("drain.stb_count", int'(bus.line_count), DEPTH);
      chk("drain.stb_ovf",   int'(bus.overflow),   0);
    end
    wait_drain();
    chk("drain.beats", beats - b0, DEPTH);
    check_state("post_fill", 0, 8'h00, 1'b0);

    // Reset in the middle of a drain abandons the line
    apply(OP_STB, 8'h61);
    apply(OP_STB, 8'h62);
    apply(OP_STB, 8'h63);
    apply(OP_RET, 8'h00);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_state("rst_mid", 0, 8'h00, 1'b0);
    chk("rst_mid.out_last", int'(bus.out_last), 0);
    chk("rst_mid.out_char", int'(bus.out_char), 0);
    exp_q.delete();
    mline.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_state("rst_rel", 0, 8'h00, 1'b0);

    rdy_rand = 1'b0;
    apply(OP_STB, 8'h37);
    apply(OP_RET, 8'h00);
    wait_drain();
    check_state("after_rst", 0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
